// File: rtl/modn_ctrl_pkg.sv
// Shared types and default sizes for the modulo-N timer controller.
package modn_ctrl_pkg;

    localparam int unsigned DefWidth = 4;
    localparam int unsigned DefRepW  = 8;

    typedef enum logic [2:0] {
        StIdle,
        StArmed,
        StRun,
        StHold,
        StDone
    } state_e;

endpackage

// File: rtl/modn_timer_ctrl_if.sv
// Configuration/command/status bundle for modn_timer_ctrl.
// Optional irq/irq_clr pair is present only when MODN_CTRL_IRQ_EN is defined.
interface modn_timer_ctrl_if
    import modn_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth,
    parameter int unsigned REP_W = DefRepW
);

    logic             cfg_valid;
    logic             cfg_ready;
    logic [WIDTH-1:0] cfg_mod;
    logic [REP_W-1:0] cfg_reps;
    logic             start;
    logic             stop;
    logic             pause;
    logic [WIDTH-1:0] cnt_out;
    logic             tc;
    logic             busy;
    logic             done;
    logic             err;

`ifdef MODN_CTRL_IRQ_EN
    logic             irq;
    logic             irq_clr;

    modport master (
        output cfg_valid, cfg_mod, cfg_reps, start, stop, pause, irq_clr,
        input  cfg_ready, cnt_out, tc, busy, done, err, irq
    );

    modport slave (
        input  cfg_valid, cfg_mod, cfg_reps, start, stop, pause, irq_clr,
        output cfg_ready, cnt_out, tc, busy, done, err, irq
    );
`else
    modport master (
        output cfg_valid, cfg_mod, cfg_reps, start, stop, pause,
        input  cfg_ready, cnt_out, tc, busy, done, err
    );

    modport slave (
        input  cfg_valid, cfg_mod, cfg_reps, start, stop, pause,
        output cfg_ready, cnt_out, tc, busy, done, err
    );
`endif

endinterface

// File: rtl/modn_count_core.sv
// Plain loadable modulo-N counter; wrap flags the cycle whose next edge returns to 0.
module modn_count_core
    import modn_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             enable_i,
    input  logic [WIDTH-1:0] mod_i,
    output logic [WIDTH-1:0] count_o,
    output logic             wrap_o
);

    logic [WIDTH-1:0] count_q, count_d;

    assign wrap_o  = enable_i && (count_q == (mod_i - WIDTH'(1)));
    assign count_o = count_q;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i) begin
            count_d = wrap_o ? '0 : count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/modn_timer_ctrl.sv
// Sequencer for modn_count_core: config handshake, run/pause/stop, period and done tracking.
// Define MODN_CTRL_IRQ_EN to add a sticky irq output with irq_clr.
module modn_timer_ctrl
    import modn_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth,
    parameter int unsigned REP_W = DefRepW
) (
    input  logic             clk,
    input  logic             rst,
    modn_timer_ctrl_if.slave bus
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] mod_q, mod_d;
    logic [REP_W-1:0] reps_q, reps_d;
    logic [REP_W-1:0] per_q, per_d;
    logic             err_q, err_d;

    logic             run_or_hold;
    logic             cfg_hs;
    logic             last_period;
    logic             cnt_clear;
    logic             cnt_en;
    logic             wrap;
    logic [WIDTH-1:0] count;

    assign run_or_hold = (state_q == StRun) || (state_q == StHold);
    assign cfg_hs      = bus.cfg_valid && bus.cfg_ready;
    assign last_period = (reps_q != '0) && (per_q == (reps_q - REP_W'(1)));

    // Count is pinned to 0 outside RUN/HOLD, so ARMED/DONE/IDLE always show 0.
    assign cnt_clear = !run_or_hold || bus.stop;
    assign cnt_en    = (state_q == StRun) && !bus.stop && !bus.pause;

    modn_count_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (cnt_clear),
        .enable_i (cnt_en),
        .mod_i    (mod_q),
        .count_o  (count),
        .wrap_o   (wrap)
    );

    always_comb begin
        state_d = state_q;
        mod_d   = mod_q;
        reps_d  = reps_q;
        per_d   = per_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle, StArmed: begin
                // A config handshake takes precedence over start.
                if (cfg_hs) begin
                    if (bus.cfg_mod == '0) begin
                        err_d   = 1'b1;
                        state_d = StIdle;
                    end else begin
                        mod_d   = bus.cfg_mod;
                        reps_d  = bus.cfg_reps;
                        err_d   = 1'b0;
                        state_d = StArmed;
                    end
                end else if ((state_q == StArmed) && bus.start) begin
                    per_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                if (bus.stop) begin
                    state_d = StArmed;
                end else if (bus.pause) begin
                    state_d = StHold;
                end else if (wrap) begin
                    per_d = per_q + REP_W'(1);
                    if (last_period) begin
                        state_d = StDone;
                    end
                end
            end
            StHold: begin
                if (bus.stop) begin
                    state_d = StArmed;
                end else if (!bus.pause) begin
                    state_d = StRun;
                end
            end
            StDone:  state_d = StArmed;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            mod_q   <= '0;
            reps_q  <= '0;
            per_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mod_q   <= mod_d;
            reps_q  <= reps_d;
            per_q   <= per_d;
            err_q   <= err_d;
        end
    end

    assign bus.cfg_ready = (state_q == StIdle) || (state_q == StArmed);
    assign bus.cnt_out   = count;
    assign bus.tc        = wrap;
    assign bus.busy      = run_or_hold;
    assign bus.done      = (state_q == StDone);
    assign bus.err       = err_q;

`ifdef MODN_CTRL_IRQ_EN
    logic irq_q, irq_d;

    // Set beats clear when both happen in the same cycle.
    always_comb begin
        irq_d = irq_q;
        if (bus.irq_clr) begin
            irq_d = 1'b0;
        end
        if ((state_q == StDone) || (err_d && !err_q)) begin
            irq_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign bus.irq = irq_q;
`endif

endmodule

// File: tb/tb_modn_timer_ctrl.sv
// Directed self-checking bench for modn_timer_ctrl (default build, WIDTH=4, REP_W=8).
module tb_modn_timer_ctrl;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    modn_timer_ctrl_if #(.WIDTH(4), .REP_W(8)) bus ();

    modn_timer_ctrl #(
        .WIDTH (4),
        .REP_W (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_cfg(input logic [3:0] m, input logic [7:0] r);
        bus.cfg_valid = 1'b1;
        bus.cfg_mod   = m;
        bus.cfg_reps  = r;
        tick();
        bus.cfg_valid = 1'b0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic pulse_stop();
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        total++; if (bus.cnt_out !== 4'd0) begin bad++;
            $display("FAIL reset_cnt got=%0d want=0", bus.cnt_out); end
        total++; if (bus.tc !== 1'b0) begin bad++;
            $display("FAIL reset_tc got=%b want=0", bus.tc); end
        total++; if (bus.busy !== 1'b0) begin bad++;
            $display("FAIL reset_busy got=%b want=0", bus.busy); end
        total++; if (bus.done !== 1'b0) begin bad++;
            $display("FAIL reset_done got=%b want=0", bus.done); end
        total++; if (bus.err !== 1'b0) begin bad++;
            $display("FAIL reset_err got=%b want=0", bus.err); end
        total++; if (bus.cfg_ready !== 1'b1) begin bad++;
            $display("FAIL reset_ready got=%b want=1", bus.cfg_ready); end
    endtask

    task automatic test_finite_run();
        int tcs;
        tcs = 0;
        load_cfg(4'd10, 8'd2);
        pulse_start();
        for (int i = 0; i < 20; i++) begin
            total++; if (bus.cnt_out !== 4'(i % 10)) begin bad++;
                $display("FAIL fin_cnt i=%0d got=%0d want=%0d", i, bus.cnt_out, i % 10); end
            total++; if (bus.tc !== ((i % 10) == 9)) begin bad++;
                $display("FAIL fin_tc i=%0d got=%b want=%b", i, bus.tc, (i % 10) == 9); end
            total++; if (bus.busy !== 1'b1) begin bad++;
                $display("FAIL fin_busy i=%0d got=%b want=1", i, bus.busy); end
            if (bus.tc === 1'b1) tcs++;
            tick();
        end
        total++; if (tcs !== 2) begin bad++;
            $display("FAIL fin_tc_count got=%0d want=2", tcs); end
        total++; if (bus.done !== 1'b1) begin bad++;
            $display("FAIL fin_done got=%b want=1", bus.done); end
        total++; if (bus.busy !== 1'b0) begin bad++;
            $display("FAIL fin_done_busy got=%b want=0", bus.busy); end
        total++; if (bus.cfg_ready !== 1'b0) begin bad++;
            $display("FAIL fin_done_ready got=%b want=0", bus.cfg_ready); end
        total++; if (bus.cnt_out !== 4'd0) begin bad++;
            $display("FAIL fin_done_cnt got=%0d want=0", bus.cnt_out); end
        tick();
        total++; if (bus.done !== 1'b0) begin bad++;
            $display("FAIL fin_done_width got=%b want=0", bus.done); end
        total++; if (bus.cfg_ready !== 1'b1) begin bad++;
            $display("FAIL fin_armed_ready got=%b want=1", bus.cfg_ready); end
        // Rerun the retained config without a new handshake.
        pulse_start();
        total++; if (bus.busy !== 1'b1) begin bad++;
            $display("FAIL fin_rerun_busy got=%b want=1", bus.busy); end
        tick();
        total++; if (bus.cnt_out !== 4'd1) begin bad++;
            $display("FAIL fin_rerun_cnt got=%0d want=1", bus.cnt_out); end
        pulse_stop();
    endtask

    task automatic test_continuous_stop();
        int tcs;
        tcs = 0;
        load_cfg(4'd5, 8'd0);
        pulse_start();
        for (int i = 0; i < 20; i++) begin
            total++; if (bus.tc !== ((i % 5) == 4)) begin bad++;
                $display("FAIL cont_tc i=%0d got=%b want=%b", i, bus.tc, (i % 5) == 4); end
            if (bus.tc === 1'b1) tcs++;
            tick();
        end
        total++; if (tcs !== 4) begin bad++;
            $display("FAIL cont_tc_count got=%0d want=4", tcs); end
        total++; if (bus.busy !== 1'b1) begin bad++;
            $display("FAIL cont_still_busy got=%b want=1", bus.busy); end
        tick();
        tick();
        total++; if (bus.cnt_out !== 4'd2) begin bad++;
            $display("FAIL cont_cnt2 got=%0d want=2", bus.cnt_out); end
        pulse_stop();
        total++; if (bus.cnt_out !== 4'd0) begin bad++;
            $display("FAIL stop_cnt got=%0d want=0", bus.cnt_out); end
        total++; if (bus.busy !== 1'b0) begin bad++;
            $display("FAIL stop_busy got=%b want=0", bus.busy); end
        total++; if (bus.cfg_ready !== 1'b1) begin bad++;
            $display("FAIL stop_ready got=%b want=1", bus.cfg_ready); end
        // Still ARMED: start alone must run.
        pulse_start();
        total++; if (bus.busy !== 1'b1) begin bad++;
            $display("FAIL stop_rearm_busy got=%b want=1", bus.busy); end
        pulse_stop();
    endtask

    task automatic test_pause();
        load_cfg(4'd10, 8'd0);
        pulse_start();
        tick();
        tick();
        tick();
        bus.pause = 1'b1;
        for (int i = 0; i < 4; i++) begin
            total++; if (bus.tc !== 1'b0) begin bad++;
                $display("FAIL pause_tc i=%0d got=%b want=0", i, bus.tc); end
            tick();
            total++; if (bus.cnt_out !== 4'd3) begin bad++;
                $display("FAIL pause_cnt i=%0d got=%0d want=3", i, bus.cnt_out); end
            total++; if (bus.busy !== 1'b1) begin bad++;
                $display("FAIL pause_busy i=%0d got=%b want=1", i, bus.busy); end
        end
        bus.pause = 1'b0;
        tick();
        total++; if (bus.cnt_out !== 4'd3) begin bad++;
            $display("FAIL resume_cnt0 got=%0d want=3", bus.cnt_out); end
        tick();
        total++; if (bus.cnt_out !== 4'd4) begin bad++;
            $display("FAIL resume_cnt1 got=%0d want=4", bus.cnt_out); end
        tick();
        total++; if (bus.cnt_out !== 4'd5) begin bad++;
            $display("FAIL resume_cnt2 got=%0d want=5", bus.cnt_out); end
        bus.pause = 1'b1;
        tick();
        pulse_stop();
        bus.pause = 1'b0;
        total++; if (bus.cnt_out !== 4'd0) begin bad++;
            $display("FAIL hold_stop_cnt got=%0d want=0", bus.cnt_out); end
        total++; if (bus.busy !== 1'b0) begin bad++;
            $display("FAIL hold_stop_busy got=%b want=0", bus.busy); end
        total++; if (bus.cfg_ready !== 1'b1) begin bad++;
            $display("FAIL hold_stop_ready got=%b want=1", bus.cfg_ready); end
    endtask

    task automatic test_bad_cfg();
        load_cfg(4'd0, 8'd5);
        total++; if (bus.err !== 1'b1) begin bad++;
            $display("FAIL bad_err got=%b want=1", bus.err); end
        pulse_start();
        total++; if (bus.busy !== 1'b0) begin bad++;
            $display("FAIL bad_start_busy got=%b want=0", bus.busy); end
        total++; if (bus.err !== 1'b1) begin bad++;
            $display("FAIL bad_err_sticky got=%b want=1", bus.err); end
        load_cfg(4'd1, 8'd3);
        total++; if (bus.err !== 1'b0) begin bad++;
            $display("FAIL mod1_err got=%b want=0", bus.err); end
        pulse_start();
        for (int i = 0; i < 3; i++) begin
            total++; if (bus.tc !== 1'b1) begin bad++;
                $display("FAIL mod1_tc i=%0d got=%b want=1", i, bus.tc); end
            total++; if (bus.cnt_out !== 4'd0) begin bad++;
                $display("FAIL mod1_cnt i=%0d got=%0d want=0", i, bus.cnt_out); end
            tick();
        end
        total++; if (bus.done !== 1'b1) begin bad++;
            $display("FAIL mod1_done got=%b want=1", bus.done); end
        total++; if (bus.tc !== 1'b0) begin bad++;
            $display("FAIL mod1_done_tc got=%b want=0", bus.tc); end
        tick();
    endtask

    task automatic test_cfg_priority();
        load_cfg(4'd3, 8'd1);
        // Config and start together: config wins, start ignored.
        bus.cfg_valid = 1'b1;
        bus.cfg_mod   = 4'd4;
        bus.cfg_reps  = 8'd1;
        bus.start     = 1'b1;
        tick();
        bus.cfg_valid = 1'b0;
        bus.start     = 1'b0;
        total++; if (bus.busy !== 1'b0) begin bad++;
            $display("FAIL prio_busy got=%b want=0", bus.busy); end
        pulse_start();
        total++; if (bus.cfg_ready !== 1'b0) begin bad++;
            $display("FAIL prio_run_ready got=%b want=0", bus.cfg_ready); end
        tick();
        tick();
        tick();
        total++; if (bus.cnt_out !== 4'd3) begin bad++;
            $display("FAIL prio_cnt got=%0d want=3", bus.cnt_out); end
        total++; if (bus.tc !== 1'b1) begin bad++;
            $display("FAIL prio_tc got=%b want=1", bus.tc); end
        tick();
        total++; if (bus.done !== 1'b1) begin bad++;
            $display("FAIL prio_done got=%b want=1", bus.done); end
        tick();
    endtask

    task automatic test_reset_mid_run();
        load_cfg(4'd10, 8'd0);
        pulse_start();
        for (int i = 0; i < 6; i++) tick();
        total++; if (bus.cnt_out !== 4'd6) begin bad++;
            $display("FAIL mid_cnt6 got=%0d want=6", bus.cnt_out); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if (bus.cnt_out !== 4'd0) begin bad++;
            $display("FAIL mid_rst_cnt got=%0d want=0", bus.cnt_out); end
        total++; if (bus.busy !== 1'b0) begin bad++;
            $display("FAIL mid_rst_busy got=%b want=0", bus.busy); end
        total++; if (bus.cfg_ready !== 1'b1) begin bad++;
            $display("FAIL mid_rst_ready got=%b want=1", bus.cfg_ready); end
        total++; if (bus.tc !== 1'b0) begin bad++;
            $display("FAIL mid_rst_tc got=%b want=0", bus.tc); end
        pulse_start();
        total++; if (bus.busy !== 1'b0) begin bad++;
            $display("FAIL mid_rst_start_busy got=%b want=0", bus.busy); end
        tick();
        total++; if (bus.cnt_out !== 4'd0) begin bad++;
            $display("FAIL mid_rst_start_cnt got=%0d want=0", bus.cnt_out); end
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        rst           = 1'b1;
        bus.cfg_valid = 1'b0;
        bus.cfg_mod   = '0;
        bus.cfg_reps  = '0;
        bus.start     = 1'b0;
        bus.stop      = 1'b0;
        bus.pause     = 1'b0;
        test_reset();
        test_finite_run();
        test_continuous_stop();
        test_pause();
        test_bad_cfg();
        test_cfg_priority();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
